// File: rtl/print_stat_trigger_gen.sv
// print_stat producer: tag FIFO, rate-limited dump strobe,
// global counter, kernel window and periodic sample strobe.
module print_stat_trigger_gen #(
  parameter int fifo_els_p        = 4,
  parameter int min_gap_p         = 2,
  parameter int period_p          = 250,
  parameter bit enable_periodic_p = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        tag_v_i,
  input  logic [31:0] tag_i,
  output logic        tag_ready_o,
  output logic        print_stat_v_o,
  output logic [31:0] print_stat_tag_o,
  output logic [31:0] global_ctr_o,
  output logic        kernel_active_o,
  output logic        periodic_v_o
);

  localparam int ptr_w =
    (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int gap_w =
    (min_gap_p > 1) ? $clog2(min_gap_p) : 1;
  localparam int ph_w = $clog2(period_p);

  typedef enum logic {
    IDLE,
    KERNEL
  } state_e;

  logic [31:0]      mem_r [fifo_els_p];
  logic [ptr_w-1:0] wr_ptr_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [cnt_w-1:0] count_r;
  logic [cnt_w-1:0] count_n;
  logic [gap_w-1:0] gap_r;
  logic [ph_w-1:0]  phase_r;
  logic             ready_r;
  logic             push;
  logic             pop;
  logic [31:0]      head;
  state_e           state_r;
  state_e           state_n;

  function automatic logic [ptr_w-1:0] ptr_inc(
    input logic [ptr_w-1:0] p
  );
    return (p == ptr_w'(fifo_els_p - 1)) ?
      '0 : p + 1'b1;
  endfunction

  assign head        = mem_r[rd_ptr_r];
  assign push        = tag_v_i & ready_r;
  assign pop         = (count_r != '0) & (gap_r == '0);
  assign tag_ready_o = ready_r;
  assign kernel_active_o = (state_r == KERNEL);

  // Occupancy after this edge; drives the registered ready.
  always_comb begin
    count_n = count_r + cnt_w'(push) - cnt_w'(pop);
  end

  // Tag storage; contents need no reset, count guards them.
  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= tag_i;
  end

  // FIFO pointers, occupancy and ready (0 in reset).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_n;
      ready_r <= (count_n != cnt_w'(fifo_els_p));
    end
  end

  // Gap throttle, registered strobe and its tag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gap_r            <= '0;
      print_stat_v_o   <= 1'b0;
      print_stat_tag_o <= '0;
    end else begin
      if (pop)
        gap_r <= gap_w'(min_gap_p - 1);
      else if (gap_r != '0)
        gap_r <= gap_r - 1'b1;
      print_stat_v_o   <= pop;
      print_stat_tag_o <= pop ? head : '0;
    end
  end

  // Kernel window follows the tag being emitted.
  always_comb begin
    state_n = state_r;
    unique case (1'b1)
      pop && state_r == IDLE &&
        head[31:30] == 2'b10:   state_n = KERNEL;
      pop && state_r == KERNEL &&
        head[31:30] == 2'b11:   state_n = IDLE;
      default:                  state_n = state_r;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Free-running counter, sample phase and periodic strobe.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      global_ctr_o <= '0;
      phase_r      <= '0;
      periodic_v_o <= 1'b0;
    end else begin
      global_ctr_o <= global_ctr_o + 32'd1;
      phase_r <= (phase_r == ph_w'(period_p - 1)) ?
        '0 : phase_r + 1'b1;
      periodic_v_o <= enable_periodic_p &&
        (state_r == KERNEL) && (phase_r == '0);
    end
  end

endmodule

// File: tb/tb_print_stat_trigger_gen.sv
// Bench for print_stat_trigger_gen: two instances
// (gap 2 + periodic/4, gap 3 + no periodic) vs a queue model.
module tb_print_stat_trigger_gen;

  localparam int PG [2] = '{2, 3};
  localparam int PP [2] = '{4, 250};
  localparam bit PE [2] = '{1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tag_v = 1'b0;
  logic [31:0] tag = '0;

  logic        rdy0, sv0, ka0, pv0;
  logic [31:0] st0, gc0;
  logic        rdy1, sv1, ka1, pv1;
  logic [31:0] st1, gc1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  int          mctr;
  bit          rdy_known;
  int          next_pop [2];
  bit          mev [2];
  logic [31:0] met [2];
  bit          mka [2];
  bit          mep [2];
  bit          macc [2];

  print_stat_trigger_gen #(
    .fifo_els_p(4), .min_gap_p(2),
    .period_p(4), .enable_periodic_p(1'b1)
  ) dut0 (
    .clk_i(clk), .reset_n_i(reset_n),
    .tag_v_i(tag_v), .tag_i(tag),
    .tag_ready_o(rdy0), .print_stat_v_o(sv0),
    .print_stat_tag_o(st0), .global_ctr_o(gc0),
    .kernel_active_o(ka0), .periodic_v_o(pv0)
  );

  print_stat_trigger_gen #(
    .fifo_els_p(4), .min_gap_p(3),
    .period_p(250), .enable_periodic_p(1'b0)
  ) dut1 (
    .clk_i(clk), .reset_n_i(reset_n),
    .tag_v_i(tag_v), .tag_i(tag),
    .tag_ready_o(rdy1), .print_stat_v_o(sv1),
    .print_stat_tag_o(st1), .global_ctr_o(gc1),
    .kernel_active_o(ka1), .periodic_v_o(pv1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [67:0] dut_vec(input int k);
    if (k == 0)
      return {rdy0 & rdy_known, sv0, st0, gc0, ka0, pv0};
    return {rdy1 & rdy_known, sv1, st1, gc1, ka1, pv1};
  endfunction

  function automatic logic [67:0] mdl_vec(input int k);
    bit r;
    r = rdy_known && (qsize(k) < 4);
    return {r, mev[k], met[k], mctr[31:0], mka[k], mep[k]};
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mctr = 0;
    rdy_known = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next_pop[k] = 0;
      mev[k] = 1'b0;
      met[k] = '0;
      mka[k] = 1'b0;
      mep[k] = 1'b0;
      macc[k] = 1'b0;
    end
  endtask

  // One clock of the spec-level behaviour: emit the oldest
  // tag when the gap since the last emission has elapsed.
  task automatic model_step(input bit v, input logic [31:0] t);
    for (int k = 0; k < 2; k++) begin
      int          sz;
      bit          nv;
      logic [31:0] nt;
      bit          np;
      sz = qsize(k);
      nv = 1'b0;
      nt = '0;
      macc[k] = v && rdy_known && (sz < 4);
      np = PE[k] && mka[k] && (mctr % PP[k] == 0);
      if (sz > 0 && mctr >= next_pop[k]) begin
        if (k == 0) nt = mq0.pop_front();
        else        nt = mq1.pop_front();
        nv = 1'b1;
        next_pop[k] = mctr + PG[k];
        if (nt[31:30] == 2'b10)      mka[k] = 1'b1;
        else if (nt[31:30] == 2'b11) mka[k] = 1'b0;
      end
      if (macc[k]) begin
        if (k == 0) mq0.push_back(t);
        else        mq1.push_back(t);
      end
      mev[k] = nv;
      met[k] = nt;
      mep[k] = np;
    end
    mctr++;
    rdy_known = 1'b1;
  endtask

  task automatic step(input bit v, input logic [31:0] t);
    tag_v = v;
    tag = t;
    model_step(v, t);
    @(posedge clk);
    @(negedge clk);
    tag_v = 1'b0;
    tag = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sv0, st0, gc0, ka0, pv0, sv1, st1, gc1, ka1, pv1}
        !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b %h %h %b %b exp zeros",
        sv0, st0, gc0, ka0, pv0);
    end
    reset_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (gc0 !== 32'd0 || gc1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctr got %h/%h exp 0", gc0, gc1);
    end
    step(1'b0, '0);
    checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1 ||
        dut_vec(0) !== mdl_vec(0) ||
        dut_vec(1) !== mdl_vec(1)) begin
      errors++;
      $display("FAIL reset_release got %h/%h exp %h/%h",
        dut_vec(0), dut_vec(1), mdl_vec(0), mdl_vec(1));
    end
  endtask

  task automatic test_single();
    while (mctr < 10) begin
      step(1'b0, '0);
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL single_idle c=%0d got %h exp %h",
          mctr, dut_vec(0), mdl_vec(0));
      end
    end
    step(1'b1, 32'h0000_0005);
    for (int i = 0; i < 6; i++) begin
      bit ev;
      ev = (mctr == 12);
      checks++;
      if (sv0 !== ev || (ev && st0 !== 32'd5) ||
          dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL single c=%0d got v=%b tag=%h exp v=%b",
          mctr, sv0, st0, ev);
      end
      step(1'b0, '0);
    end
  endtask

  task automatic test_burst();
    int          cyc [$];
    logic [31:0] tg [$];
    bit          drop;
    drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rdy0 !== 1'b1) drop = 1'b1;
      step(1'b1, 32'h100 + i);
      if (sv0) begin cyc.push_back(mctr); tg.push_back(st0); end
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL burst c=%0d got %h/%h exp %h/%h", mctr,
          dut_vec(0), dut_vec(1), mdl_vec(0), mdl_vec(1));
      end
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b0, '0);
      if (sv0) begin cyc.push_back(mctr); tg.push_back(st0); end
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL burst_drain c=%0d got %h exp %h",
          mctr, dut_vec(0), mdl_vec(0));
      end
    end
    checks++;
    if (drop) begin
      errors++;
      $display("FAIL burst_ready got dropped exp always 1");
    end
    checks++;
    if (cyc.size() != 4) begin
      errors++;
      $display("FAIL burst_count got %0d exp 4", cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tg[i] !== 32'h100 + i ||
            (i > 0 && cyc[i] - cyc[i-1] != 2)) begin
          errors++;
          $display("FAIL burst_order i=%0d got %h gap %0d exp %h",
            i, tg[i], (i > 0) ? cyc[i] - cyc[i-1] : 0,
            32'h100 + i);
        end
      end
    end
  endtask

  task automatic test_full();
    int          cyc [$];
    logic [31:0] tg [$];
    int          idx;
    bit          low;
    idx = 0;
    low = 1'b0;
    for (int n = 0; n < 60 && idx < 8; n++) begin
      if (rdy1 === 1'b0) low = 1'b1;
      step(1'b1, 32'h200 + idx);
      if (macc[1]) idx++;
      if (sv1) begin cyc.push_back(mctr); tg.push_back(st1); end
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL full c=%0d got %h/%h exp %h/%h", mctr,
          dut_vec(0), dut_vec(1), mdl_vec(0), mdl_vec(1));
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0);
      if (sv1) begin cyc.push_back(mctr); tg.push_back(st1); end
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL full_drain c=%0d got %h exp %h",
          mctr, dut_vec(1), mdl_vec(1));
      end
    end
    checks++;
    if (!low) begin
      errors++;
      $display("FAIL full_ready got never low exp low when full");
    end
    checks++;
    if (cyc.size() != 8) begin
      errors++;
      $display("FAIL full_count got %0d exp 8", cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (tg[i] !== 32'h200 + i ||
            (i > 0 && cyc[i] - cyc[i-1] != 3)) begin
          errors++;
          $display("FAIL full_order i=%0d got %h exp %h",
            i, tg[i], 32'h200 + i);
        end
      end
    end
  endtask

  task automatic test_kernel();
    int  cs;
    int  ce;
    int  npv;
    bit  ka_prev;
    cs = mctr;
    ce = cs + 24;
    npv = 0;
    ka_prev = 1'b0;
    for (int j = 0; j < 50; j++) begin
      int  c;
      bit  eka;
      bit  epv;
      c = mctr;
      eka = (c >= cs + 2) && (c < ce + 2);
      epv = ka_prev && ((c - 1) % 4 == 0);
      if (pv0) npv++;
      checks++;
      if (ka0 !== eka || pv0 !== epv || pv1 !== 1'b0 ||
          ka1 !== eka ||
          dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL kernel c=%0d got ka=%b pv=%b exp ka=%b pv=%b",
          c, ka0, pv0, eka, epv);
      end
      ka_prev = eka;
      if (c == cs)      step(1'b1, 32'h8000_0000);
      else if (c == ce) step(1'b1, 32'hC000_0000);
      else              step(1'b0, '0);
    end
    checks++;
    if (npv != 6) begin
      errors++;
      $display("FAIL kernel_periodic_count got %0d exp 6", npv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      bit          v;
      t = $urandom;
      v = ($urandom_range(0, 1) == 1);
      step(v, t);
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL random c=%0d got %h/%h exp %h/%h", mctr,
          dut_vec(0), dut_vec(1), mdl_vec(0), mdl_vec(1));
      end
    end
  endtask

  task automatic test_async_reset();
    int nsv;
    nsv = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'h8000_0300 + i);
    checks++;
    if (qsize(1) < 3) begin
      errors++;
      $display("FAIL areset_setup got %0d buffered exp >=3",
        qsize(1));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sv0, st0, gc0, ka0, pv0, sv1, st1, gc1, ka1, pv1}
        !== '0) begin
      errors++;
      $display("FAIL areset_async got %b %h %h %b exp zeros",
        sv0, st0, gc0, ka0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (gc0 !== 32'd0 || gc1 !== 32'd0) begin
      errors++;
      $display("FAIL areset_ctr got %h exp 0", gc0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0);
      if (sv0 || sv1) nsv++;
      checks++;
      if (dut_vec(0) !== mdl_vec(0) ||
          dut_vec(1) !== mdl_vec(1)) begin
        errors++;
        $display("FAIL areset_after c=%0d got %h exp %h",
          mctr, dut_vec(0), mdl_vec(0));
      end
    end
    checks++;
    if (nsv != 0) begin
      errors++;
      $display("FAIL areset_stale got %0d strobes exp 0", nsv);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_kernel();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
